// File: rtl/count_event_queue.sv
// Event classifier for an up/down counter's output: each sample is compared
// with the previous one and at most one event is queued in a show-ahead FIFO.
module count_event_queue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     count_valid,
    input  logic [WIDTH-1:0]         cfg_threshold,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [1:0]               evt_code,
    output logic [WIDTH-1:0]         evt_value,
    output logic [$clog2(DEPTH):0]   evt_level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);

    typedef enum logic [1:0] {
        WRAP_UP = 2'd0,
        WRAP_DN = 2'd1,
        JUMP    = 2'd2,
        MATCH   = 2'd3
    } evt_code_t;

    typedef struct packed {
        evt_code_t        code;
        logic [WIDTH-1:0] value;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [WIDTH-1:0]  prev_q;
    logic              primed_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              overflow_q;

    logic              has_evt;
    evt_code_t         code_n;
    logic              is_step;
    logic [WIDTH:0]    c_ext;
    logic [WIDTH:0]    p_ext;
    logic              sample;
    logic              push_req;
    logic              push;
    logic              pop;
    logic              full;
    logic              drop;

    // Steps are compared one bit wider so MAX+1 and 0-1 never alias a wrap.
    assign c_ext   = {1'b0, count_in};
    assign p_ext   = {1'b0, prev_q};
    assign is_step = (c_ext == p_ext) || (c_ext == p_ext + ONE_EXT) ||
                     (c_ext + ONE_EXT == p_ext);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        has_evt = 1'b0;
        code_n  = WRAP_UP;
        if (prev_q == CNT_MAX && count_in == '0) begin
            has_evt = 1'b1;
            code_n  = WRAP_UP;
        end else if (prev_q == '0 && count_in == CNT_MAX) begin
            has_evt = 1'b1;
            code_n  = WRAP_DN;
        end else if (is_step) begin
            if (count_in == cfg_threshold && prev_q != cfg_threshold) begin
                has_evt = 1'b1;
                code_n  = MATCH;
            end
        end else begin
            has_evt = 1'b1;
            code_n  = JUMP;
        end
    end

    assign sample   = count_valid && !rst;
    assign push_req = sample && primed_q && has_evt;
    assign full     = (level_q == LW'(DEPTH));
    assign pop      = (level_q != '0) && evt_ready && !rst;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (sample) begin
                prev_q   <= count_in;
                primed_q <= 1'b1;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    // NOTE: storage is not reset; the outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= '{code: code_n, value: count_in};
    end

    assign evt_valid = (level_q != '0);
    assign evt_code  = evt_valid ? mem[rd_ptr_q].code  : WRAP_UP;
    assign evt_value = evt_valid ? mem[rd_ptr_q].value : '0;
    assign evt_level = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_event_queue.sv
// Directed bench for count_event_queue (WIDTH=4, DEPTH=4) with hand-computed
// expected codes, values, levels and overflow flags.
module tb_count_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = '0;
    logic       count_valid = 1'b0;
    logic [3:0] cfg_threshold = '0;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [1:0] evt_code;
    logic [3:0] evt_value;
    logic [2:0] evt_level;
    logic       overflow;
    logic       ovf_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    count_event_queue #(.WIDTH(4), .DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .count_in      (count_in),
        .count_valid   (count_valid),
        .cfg_threshold (cfg_threshold),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_code      (evt_code),
        .evt_value     (evt_value),
        .evt_level     (evt_level),
        .overflow      (overflow),
        .ovf_clr       (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] v);
        count_in    = v;
        count_valid = 1'b1;
        tick();
        count_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    task automatic head(input string tag, input int code, input int value);
        check({tag, "_valid"}, int'(evt_valid), 1);
        check({tag, "_code"},  int'(evt_code),  code);
        check({tag, "_value"}, int'(evt_value), value);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code",  int'(evt_code),  0);
        check("rst_value", int'(evt_value), 0);
        check("rst_level", int'(evt_level), 0);
        check("rst_ovf",   int'(overflow),  0);

        // Threshold match on a step
        cfg_threshold = 4'd2;
        sample(4'd0);
        check("prime_level", int'(evt_level), 0);
        sample(4'd1);
        check("step_level", int'(evt_level), 0);
        sample(4'd2);
        check("match_level", int'(evt_level), 1);
        head("match", 3, 2);
        sample(4'd2);
        sample(4'd2);
        check("hold_level", int'(evt_level), 1);
        pop_one();
        check("drain_valid", int'(evt_valid), 0);
        check("drain_level", int'(evt_level), 0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("empty_pop_level", int'(evt_level), 0);

        // Wraps in both directions
        do_reset();
        cfg_threshold = 4'd9;
        sample(4'd14);
        sample(4'd15);
        check("pre_wrap_level", int'(evt_level), 0);
        sample(4'd0);
        check("wrap_up_level", int'(evt_level), 1);
        head("wrap_up", 0, 0);
        sample(4'd1);
        sample(4'd0);
        sample(4'd15);
        check("wrap_dn_level", int'(evt_level), 2);
        head("wrap_dn_head", 0, 0);
        pop_one();
        head("wrap_dn", 1, 15);
        pop_one();
        check("wrap_empty", int'(evt_valid), 0);

        // JUMP beats MATCH, then a step off the threshold
        do_reset();
        cfg_threshold = 4'd9;
        sample(4'd3);
        sample(4'd9);
        head("jump", 2, 9);
        sample(4'd10);
        check("after_jump_level", int'(evt_level), 1);
        pop_one();

        // Overflow, pop+push on a full FIFO, set-over-clear priority
        do_reset();
        cfg_threshold = 4'd9;
        sample(4'd0);
        sample(4'd5);
        sample(4'd10);
        sample(4'd0);
        sample(4'd5);
        check("full_ovf_before", int'(overflow), 0);
        sample(4'd10);
        check("full_level", int'(evt_level), 4);
        check("full_ovf",   int'(overflow),  1);
        head("full_head", 2, 5);
        evt_ready = 1'b1;
        sample(4'd0);
        evt_ready = 1'b0;
        check("pp_level", int'(evt_level), 4);
        head("pp_head", 2, 10);
        count_in = 4'd8;
        count_valid = 1'b1;
        ovf_clr = 1'b1;
        tick();
        count_valid = 1'b0;
        check("set_beats_clr", int'(overflow), 1);
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        head("order0", 2, 10);
        pop_one();
        head("order1", 2, 0);
        pop_one();
        head("order2", 2, 5);
        pop_one();
        head("order3", 2, 0);
        pop_one();
        check("order_empty", int'(evt_level), 0);

        // Mid-operation reset
        do_reset();
        sample(4'd0);
        sample(4'd5);
        sample(4'd10);
        check("pre_rst_level", int'(evt_level), 2);
        do_reset();
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_level", int'(evt_level), 0);
        sample(4'd7);
        check("reprime_level", int'(evt_level), 0);
        sample(4'd8);
        check("post_rst_step", int'(evt_level), 0);

        // Unqualified cycles leave prev untouched
        do_reset();
        sample(4'd2);
        count_valid = 1'b0;
        count_in = 4'd2;
        tick();
        count_in = 4'd12;
        tick();
        check("cv0_level", int'(evt_level), 0);
        count_in = 4'd3;
        tick();
        sample(4'd3);
        check("cv_step_level", int'(evt_level), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
